// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: registered N-way select mux with valid/ready handshake.
// The two-entry main/skid buffer absorbs downstream stalls without loss.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_ready  upstream handshake (in_ready is a register)
//   sel, data           select and flattened inputs, sampled on accept
//   out_valid, out_ready  downstream handshake
//   out_data, out_sel_err  head entry (value, illegal-select flag)
//   clr_err, err_cnt    clear and saturating count of illegal accepts
module sel_mux_pipe #(
  parameter int              WIDTH  = 32,
  parameter int              N      = 4,
  parameter int              SELW   = 2,
  parameter logic [WIDTH-1:0] DEFVAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sel_err,
  input  logic               clr_err,
  output logic [15:0]        err_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] val;
  } ent_t;

  state_t state_q, state_d;
  ent_t   main_q, skid_q;
  ent_t   ent_d, main_d;
  logic   rdy_q;
  logic   acc, pop;
  logic   wr_main, wr_skid;
  logic   ill_acc;

  assign acc       = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;
  assign ill_acc   = acc & ent_d.err;
  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data    = main_q.val;
  assign out_sel_err = main_q.err;

  // Loop over legal inputs only, so an out-of-range sel never indexes
  // past the bus and falls through to DEFVAL.
  always_comb begin
    ent_d.val = DEFVAL;
    ent_d.err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        ent_d.val = data[k*WIDTH +: WIDTH];
        ent_d.err = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wr_main = 1'b0;
    wr_skid = 1'b0;
    main_d  = ent_d;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          wr_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          wr_main = 1'b1;
        end else if (acc) begin
          state_d = TWO;
          wr_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          wr_main = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered ready: look ahead at the next state.
      rdy_q   <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (wr_main) main_q <= main_d;
      if (wr_skid) skid_q <= ent_d;
    end
  end

  // Clear wins over the old count but still counts a same-cycle
  // illegal accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= ill_acc ? 16'd1 : 16'd0;
    end else if (ill_acc && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: an N=4 and an N=3 instance share one stimulus.
// A negedge monitor scoreboards every pop against a reference model.
module tb_sel_mux_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   sel;
  logic [127:0] data;
  logic         out_ready;
  logic         clr_err;

  logic         r4, v4, e4;
  logic [31:0]  d4;
  logic [15:0]  c4;
  logic         r3, v3, e3;
  logic [31:0]  d3;
  logic [15:0]  c3;

  int checks   = 0;
  int failures = 0;
  int n4 = 0;
  int n3 = 0;

  logic [32:0] q4[$];
  logic [32:0] q3[$];

  localparam logic [31:0] DEF = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  sel_mux_pipe #(.WIDTH(32), .N(4), .SELW(2), .DEFVAL('0)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r4),
    .sel(sel), .data(data),
    .out_valid(v4), .out_ready(out_ready),
    .out_data(d4), .out_sel_err(e4),
    .clr_err(clr_err), .err_cnt(c4)
  );

  sel_mux_pipe #(.WIDTH(32), .N(3), .SELW(2), .DEFVAL(DEF)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r3),
    .sel(sel), .data(data[95:0]),
    .out_valid(v3), .out_ready(out_ready),
    .out_data(d3), .out_sel_err(e3),
    .clr_err(clr_err), .err_cnt(c3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model4(logic [1:0] s, logic [127:0] d);
    logic [31:0] w;
    w = d[s*32 +: 32];
    return {1'b0, w};
  endfunction

  function automatic logic [32:0] model3(logic [1:0] s, logic [127:0] d);
    logic [31:0] w;
    if (s == 2'd3) return {1'b1, DEF};
    w = d[s*32 +: 32];
    return {1'b0, w};
  endfunction

  // Scoreboard: push on a handshake that will accept at the next edge,
  // pop/compare on a handshake that will pop at the next edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n !== 1'b1) begin
      q4.delete();
      q3.delete();
    end else begin
      if (v4 && out_ready) begin
        chk("u4_underflow", 32'(q4.size() != 0), 32'd1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          chk("u4_data", d4, e[31:0]);
          chk("u4_err", 32'(e4), 32'(e[32]));
          n4++;
        end
      end
      if (v3 && out_ready) begin
        chk("u3_underflow", 32'(q3.size() != 0), 32'd1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          chk("u3_data", d3, e[31:0]);
          chk("u3_err", 32'(e3), 32'(e[32]));
          n3++;
        end
      end
      if (in_valid && r4) q4.push_back(model4(sel, data));
      if (in_valid && r3) q3.push_back(model3(sel, data));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  localparam logic [127:0] BASE = {32'h44, 32'h33, 32'h22, 32'h11};

  initial begin
    int b4;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = '0;
    data      = BASE;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    // Reset state
    cyc();
    cyc();
    mid();
    chk("rst_ov", 32'(v4), 32'd0);
    chk("rst_ir", 32'(r4), 32'd0);
    chk("rst_data", d4, 32'd0);
    chk("rst_err", 32'(e4), 32'd0);
    chk("rst_cnt", 32'(c3), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    mid();
    chk("post_rst_ir", 32'(r4), 32'd1);
    chk("post_rst_ov", 32'(v4), 32'd0);

    // Passthrough with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 2'd2;
    cyc();
    sel = 2'd0;
    mid();
    chk("pt_ov", 32'(v4), 32'd1);
    chk("pt_sel2", d4, 32'h33);
    cyc();
    sel = 2'd1;
    mid();
    chk("pt_sel0", d4, 32'h11);
    cyc();
    sel = 2'd3;
    mid();
    chk("pt_sel1", d4, 32'h22);
    cyc();
    in_valid = 1'b0;
    mid();
    chk("pt_sel3", d4, 32'h44);
    chk("pt_err4", 32'(e4), 32'd0);
    chk("ill_data", d3, DEF);
    chk("ill_err", 32'(e3), 32'd1);
    chk("ill_cnt", 32'(c3), 32'd1);
    chk("n4_cnt", 32'(c4), 32'd0);
    cyc();
    mid();
    chk("idle_ov", 32'(v4), 32'd0);
    chk("idle_hold", d4, 32'h44);

    // Legal select after an illegal one
    in_valid = 1'b1;
    sel      = 2'd1;
    cyc();
    in_valid = 1'b0;
    mid();
    chk("leg_err", 32'(e3), 32'd0);
    chk("leg_cnt", 32'(c3), 32'd1);

    // Backpressure: A, B fill the buffer, C waits
    cyc();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    data      = {96'h0, 32'h0000_00A1} << 32;
    mid();
    chk("bp_ir0", 32'(r4), 32'd1);
    cyc();
    data = {96'h0, 32'h0000_00B2} << 32;
    mid();
    chk("bp_ir1", 32'(r4), 32'd1);
    cyc();
    data = {96'h0, 32'h0000_00C3} << 32;
    mid();
    chk("bp_ir2", 32'(r4), 32'd0);
    chk("bp_headA", d4, 32'hA1);
    cyc();
    mid();
    chk("bp_ir3", 32'(r4), 32'd0);
    chk("bp_holdA", d4, 32'hA1);
    cyc();
    out_ready = 1'b1;
    mid();
    chk("bp_popA", d4, 32'hA1);
    cyc();
    mid();
    chk("bp_ir4", 32'(r4), 32'd1);
    chk("bp_B", d4, 32'hB2);
    cyc();
    in_valid = 1'b0;
    mid();
    chk("bp_C", d4, 32'hC3);
    cyc();
    mid();
    chk("bp_empty", 32'(v4), 32'd0);

    // Sustained random traffic, accept and pop every cycle
    b4 = n4;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel  = 2'($urandom_range(0, 3));
      data = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      if (i == 50) begin
        mid();
        chk("rnd_ir", 32'(r4), 32'd1);
        chk("rnd_ov", 32'(v4), 32'd1);
      end
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    mid();
    chk("rnd_count", 32'(n4 - b4), 32'd100);
    chk("rnd_q", 32'(q4.size()), 32'd0);

    // Counter edges
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    mid();
    chk("clr_first", 32'(c3), 32'd0);
    cyc();
    in_valid = 1'b1;
    sel      = 2'd3;
    data     = BASE;
    repeat (65534) cyc();
    cyc();
    in_valid = 1'b0;
    mid();
    chk("cnt_ffff", 32'(c3), 32'hFFFF);
    chk("cnt_n4", 32'(c4), 32'd0);
    chk("err_n4", 32'(e4), 32'd0);
    cyc();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    mid();
    chk("cnt_sat", 32'(c3), 32'hFFFF);
    cyc();
    in_valid = 1'b1;
    clr_err  = 1'b1;
    cyc();
    in_valid = 1'b0;
    clr_err  = 1'b0;
    mid();
    chk("clr_ill", 32'(c3), 32'd1);
    cyc();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    mid();
    chk("clr_only", 32'(c3), 32'd0);

    // Reset with the buffer full
    cyc();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    data      = {32'h5A5A_0003, 96'h0};
    cyc();
    data = {32'h6B6B_0003, 96'h0};
    cyc();
    in_valid = 1'b0;
    mid();
    chk("full_ir", 32'(r4), 32'd0);
    chk("full_ov", 32'(v4), 32'd1);
    cyc();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    mid();
    chk("mrst_ov", 32'(v4), 32'd0);
    chk("mrst_cnt", 32'(c3), 32'd0);
    chk("mrst_ir", 32'(r4), 32'd0);
    chk("mrst_data", d4, 32'd0);
    cyc();
    mid();
    chk("mrst_ir1", 32'(r4), 32'd1);
    chk("mrst_ov1", 32'(v4), 32'd0);
    cyc();
    in_valid = 1'b1;
    sel      = 2'd0;
    data     = BASE;
    cyc();
    in_valid = 1'b0;
    mid();
    chk("mrst_fresh", d4, 32'h11);
    cyc();
    cyc();
    mid();
    chk("end_q4", 32'(q4.size()), 32'd0);
    chk("end_q3", 32'(q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
